// File: rtl/ita_activation_collector_pkg.sv
// Shared types and sizing for the ITA activation collector.
//  requant_oup_t   : one activation beat, NUM_LANES bytes
//  COLLECTOR_DEPTH : default result FIFO depth
//  ACT_LATENCY     : fixed latency of the activation stage being tracked
//  ptr_w()         : pointer width for a DEPTH-entry ring (at least 1 bit)
package ita_activation_collector_pkg;
  localparam int NUM_LANES       = 4;
  localparam int COLLECTOR_DEPTH = 4;
  localparam int ACT_LATENCY     = 2;

  typedef logic [NUM_LANES-1:0][7:0] requant_oup_t;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/ita_activation_collector_if.sv
// Handshake bundle between upstream issue, the activation stage result,
// and the downstream output path.
//  slave  : collector side (takes in_valid_i/act_data_i/out_ready_i)
//  master : environment side (drives issue, activation data and ready)
interface ita_activation_collector_if #(
  parameter int DEPTH = ita_activation_collector_pkg::COLLECTOR_DEPTH
);
  import ita_activation_collector_pkg::*;

  logic                       in_valid_i;
  logic                       in_ready_o;
  requant_oup_t               act_data_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  requant_oup_t               out_data_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  modport slave (
    input  in_valid_i, act_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );

  modport master (
    output in_valid_i, act_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface

// File: rtl/ita_collector_fifo.sv
// Result storage for the activation collector: DEPTH-entry ring buffer with
// occupancy count. DEPTH need not be a power of two.
//  clk_i, rst_i : clock, synchronous active-high reset (pointers/count only)
//  push, push_data : write push_data at the write pointer
//  pop          : advance the read pointer (caller guarantees !empty)
//  rd_data      : entry at the read pointer, combinational
//  full, empty, count : occupancy status
module ita_collector_fifo
  import ita_activation_collector_pkg::*;
#(
  parameter int DEPTH = COLLECTOR_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  requant_oup_t               push_data,
  input  logic                       pop,
  output requant_oup_t               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  requant_oup_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // storage is not reset; contents are only observed when count != 0
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/ita_activation_collector.sv
// Receive side of the ITA activation stage. The stage has a fixed LATENCY and
// no handshake, so each issued beat is tracked through a valid shift register
// and its result captured into a small FIFO. Upstream issue is gated by a
// credit counter that reserves a FIFO slot for every beat in flight, so a
// capture can never find the FIFO full.
//  clk_i, rst_i : clock, synchronous active-high reset
//  bus (slave)  : in_valid_i/in_ready_o issue handshake, act_data_i stage
//                 result, out_valid_o/out_ready_i/out_data_o output path,
//                 count_o FIFO occupancy (in-flight beats excluded)
// Build option ITA_COLLECTOR_BYPASS_EN: when the FIFO is empty a beat leaving
// the pipeline is presented on the output in the same cycle and, if accepted,
// never written to the FIFO.
module ita_activation_collector
  import ita_activation_collector_pkg::*;
#(
  parameter int LATENCY = ACT_LATENCY,
  parameter int DEPTH   = COLLECTOR_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  ita_activation_collector_if.slave     bus
);
  localparam int CW = $clog2(DEPTH+1);

  logic [LATENCY-1:0] vld_pipe;
  logic [CW-1:0]      cr;
  logic               iss, cap, ret, push, fifo_pop;
  logic               full, empty;
  requant_oup_t       rd_data;
  logic [CW-1:0]      fcount;

  assign bus.in_ready_o = (cr != '0) & ~rst_i;
  assign iss            = bus.in_valid_i & bus.in_ready_o;
  assign cap            = vld_pipe[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      cr       <= CW'(DEPTH);
    end else begin
      vld_pipe[0] <= iss;
      for (int k = 1; k < LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
      cr <= cr - CW'(iss) + CW'(ret);
    end
  end

`ifdef ITA_COLLECTOR_BYPASS_EN
  logic byp_take;

  assign bus.out_valid_o = ~empty | cap;
  assign bus.out_data_o  = empty ? bus.act_data_i : rd_data;
  assign byp_take        = empty & cap & bus.out_ready_i;
  assign fifo_pop        = ~empty & bus.out_ready_i;
  // the full term is defensive; credits already guarantee a free slot
  assign push            = cap & ~byp_take & (~full | fifo_pop);
  assign ret             = bus.out_valid_o & bus.out_ready_i;
`else
  assign bus.out_valid_o = ~empty;
  assign bus.out_data_o  = rd_data;
  assign fifo_pop        = ~empty & bus.out_ready_i;
  assign push            = cap & (~full | fifo_pop);
  assign ret             = fifo_pop;
`endif

  assign bus.count_o = fcount;

  ita_collector_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (bus.act_data_i),
    .pop       (fifo_pop),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (fcount)
  );
endmodule

// File: tb/tb_ita_activation_collector.sv
// Bench for ita_activation_collector: models the fixed-latency activation
// stage, keeps a scoreboard of issued beats and a reference model of
// occupancy/credit, plus a per-cycle vector table and corner-case sequences.
module tb_ita_activation_collector;
  import ita_activation_collector_pkg::*;

  localparam int LAT = ACT_LATENCY;
  localparam int DEP = COLLECTOR_DEPTH;
`ifdef ITA_COLLECTOR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ita_activation_collector_if #(.DEPTH(DEP)) bus();

  ita_activation_collector #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // activation stage model: result of a beat issued in cycle c is on act_data_i in cycle c+LAT
  requant_oup_t in_data;
  requant_oup_t apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= (bus.in_valid_i && bus.in_ready_o) ? in_data : {NUM_LANES{8'hEE}};
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign bus.act_data_i = apipe[LAT-1];

  // reference model + scoreboard, evaluated mid-cycle
  requant_oup_t     exp_q [$];
  requant_oup_t     exp_d;
  int               mcount = 0;
  int               mout   = 0;
  logic [LAT-1:0]   mv     = '0;
  bit               mon_en = 1'b0;
  bit               m_cap, m_ov, m_ir, m_iss, m_pop, m_take;

  always @(negedge clk) begin
    if (mon_en) begin
      m_cap = mv[LAT-1];
      m_ov  = (mcount != 0) || (BYP && m_cap);
      m_ir  = !rst && (mout < DEP);
      chk("in_ready", 64'(bus.in_ready_o), 64'(m_ir));
      chk("out_valid", 64'(bus.out_valid_o), 64'(m_ov));
      chk("count", 64'(bus.count_o), 64'(mcount));
      if (rst) begin
        mcount = 0;
        mout   = 0;
        mv     = '0;
        exp_q.delete();
      end else begin
        m_iss  = bus.in_valid_i && m_ir;
        m_pop  = m_ov && bus.out_ready_i;
        m_take = BYP && (mcount == 0) && m_cap && bus.out_ready_i;
        if (m_iss) exp_q.push_back(in_data);
        if (m_pop) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'(1));
          end else begin
            exp_d = exp_q.pop_front();
            chk("out_data", 64'(bus.out_data_o), 64'(exp_d));
          end
        end
        mcount += ((m_cap && !m_take) ? 1 : 0) - ((m_pop && !m_take) ? 1 : 0);
        mout   += (m_iss ? 1 : 0) - (m_pop ? 1 : 0);
        for (int k = LAT-1; k > 0; k--) mv[k] = mv[k-1];
        mv[0] = m_iss;
      end
    end
  end

  typedef struct {
    bit iv;
    bit rdy;
    bit ir;
    bit ov;
    int cnt;
  } vec_t;
  vec_t tbl [16];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first_ov, maxc, nout, waited;

    // backpressure then release, expected state sampled mid-cycle
    tbl[0]  = '{1, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 1, 1};
    tbl[4]  = '{1, 0, 0, 1, 2};
    tbl[5]  = '{1, 0, 0, 1, 3};
    tbl[6]  = '{1, 0, 0, 1, 4};
    tbl[7]  = '{1, 1, 0, 1, 4};
    tbl[8]  = '{1, 1, 1, 1, 3};
    tbl[9]  = '{1, 1, 1, 1, 2};
    tbl[10] = '{1, 1, 1, 1, 1};
    tbl[11] = '{1, 1, 1, 1, 1};
    tbl[12] = '{0, 1, 1, 1, 1};
    tbl[13] = '{0, 1, 1, 1, 1};
    tbl[14] = '{0, 1, 1, 1, 1};
    tbl[15] = '{0, 1, 1, 0, 0};

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    in_data         = '0;

    // reset
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready_o), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid_o), 64'(0));
    chk("reset_count", 64'(bus.count_o), 64'(0));
    chk("reset_ready_after", 64'(bus.in_ready_o), 64'(1));
    next_cycle();

    // streaming, 8 beats at full rate
    first_ov = -1; maxc = 0; nout = 0;
    for (int c = 0; c < 16; c++) begin
      bus.in_valid_i  = (c < 8);
      bus.out_ready_i = 1'b1;
      in_data         = {NUM_LANES{8'(8'h10 + c)}};
      @(negedge clk);
      if (c < 8) chk("stream_in_ready", 64'(bus.in_ready_o), 64'(1));
      if (bus.out_valid_o && first_ov < 0) first_ov = c;
      if (int'(bus.count_o) > maxc) maxc = int'(bus.count_o);
      if (bus.out_valid_o) nout++;
      next_cycle();
    end
    chk("stream_first_valid", 64'(first_ov), 64'(BYP ? LAT : LAT + 1));
    chk("stream_max_count", 64'(maxc), 64'(BYP ? 0 : 1));
    chk("stream_outputs", 64'(nout), 64'(8));

`ifndef ITA_COLLECTOR_BYPASS_EN
    // table-driven backpressure/release
    for (int i = 0; i < 16; i++) begin
      bus.in_valid_i  = tbl[i].iv;
      bus.out_ready_i = tbl[i].rdy;
      in_data         = {NUM_LANES{8'(8'h20 + i)}};
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready_o), 64'(tbl[i].ir));
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid_o), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d_count", i), 64'(bus.count_o), 64'(tbl[i].cnt));
      next_cycle();
    end
`endif

    // fill to full, then stream through a full FIFO so both pointers wrap
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    waited = 0;
    while (bus.count_o != 3'(DEP) && waited < 20) begin
      in_data = {NUM_LANES{8'(8'h40 + waited)}};
      next_cycle();
      waited++;
    end
    chk("fill_reached_full", 64'(bus.count_o), 64'(DEP));
    for (int c = 0; c < 14; c++) begin
      bus.in_valid_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      in_data         = {NUM_LANES{8'(8'h60 + c)}};
      next_cycle();
    end
    bus.in_valid_i = 1'b0;
    repeat (8) next_cycle();
    chk("wrap_drained", 64'(bus.count_o), 64'(0));

    // reset with beats in flight and stored
    bus.out_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid_i = 1'b1;
      in_data        = {NUM_LANES{8'(8'h80 + c)}};
      next_cycle();
    end
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("flush_pre_count", 64'(bus.count_o), 64'(2));
    chk("flush_rst_in_ready", 64'(bus.in_ready_o), 64'(0));
    next_cycle();
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(bus.out_valid_o), 64'(0));
    chk("flush_count", 64'(bus.count_o), 64'(0));
    chk("flush_in_ready", 64'(bus.in_ready_o), 64'(1));
    nout = 0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      if (bus.out_valid_o) nout++;
    end
    chk("flush_no_output", 64'(nout), 64'(0));
    next_cycle();

`ifdef ITA_COLLECTOR_BYPASS_EN
    // bypass: result appears on the output in its capture cycle
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    in_data         = {NUM_LANES{8'hAB}};
    next_cycle();
    bus.in_valid_i = 1'b0;
    for (int c = 1; c < LAT; c++) next_cycle();
    @(negedge clk);
    chk("bypass_valid", 64'(bus.out_valid_o), 64'(1));
    chk("bypass_data", 64'(bus.out_data_o), 64'({NUM_LANES{8'hAB}}));
    chk("bypass_count", 64'(bus.count_o), 64'(0));
    next_cycle();
    @(negedge clk);
    chk("bypass_count_after", 64'(bus.count_o), 64'(0));
    next_cycle();
`endif

    // random valid/ready against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid_i  = ($urandom_range(0, 99) < 60);
      bus.out_ready_i = ($urandom_range(0, 99) < 55);
      in_data         = requant_oup_t'($urandom);
      next_cycle();
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (LAT + DEP + 4) next_cycle();
    chk("random_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("random_count_zero", 64'(bus.count_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
